// File: rtl/cpu_pkg.sv
// Shared definitions for the small CPU core: default widths, the HALT opcode
// and the fetch-sequencer state encoding.
package cpu_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 8;

    localparam logic [3:0] OPC_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load a target, increment with natural wraparound,
// or hold. Load wins if both are requested.
module program_counter #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_addr,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE -> FETCH (request until ack) -> EXEC
// (hold on stall, then halt, jump or fall through) -> FETCH, with HALT terminal.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         opcode,
    output logic [3:0]         operand,
    output logic               instr_valid,
    input  logic               jmp_sel,
    input  logic [PC_W-1:0]    jmp_addr,
    input  logic               stall,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted,
    output logic [1:0]         state_dbg
);

    // imem handshake: imem_req is high for every FETCH cycle and the word is
    // taken on the first cycle where imem_req && imem_ack; ack is ignored otherwise.

    fetch_state_t       state, state_nxt;
    logic [INSTR_W-1:0] ir;
    logic               ir_load;
    logic               pc_inc;
    logic               pc_load;
    logic [PC_W-1:0]    pc;

    program_counter #(.PC_W(PC_W)) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pc_load),
        .inc       (pc_inc),
        .load_addr (jmp_addr),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                ir <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_load   = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // HALT outranks a taken jump; the PC stays at the post-increment value.
                if (!stall) begin
                    if (opcode == OPC_HALT) begin
                        state_nxt = ST_HALT;
                    end else begin
                        pc_load   = jmp_sel;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_EXEC);
    assign halted      = (state == ST_HALT);
    assign opcode      = ir[INSTR_W-1 -: 4];
    assign operand     = ir[3:0];
    assign pc_out      = pc;
    assign state_dbg   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change and outputs are checked on the
// falling edge, so every rising edge commits exactly one step.
module tb_fetch_unit;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_valid;
    logic       jmp_sel;
    logic [7:0] jmp_addr;
    logic       stall;
    logic [7:0] pc_out;
    logic       halted;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.PC_W(8), .INSTR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .jmp_sel     (jmp_sel),
        .jmp_addr    (jmp_addr),
        .stall       (stall),
        .pc_out      (pc_out),
        .halted      (halted),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic idle_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        jmp_sel    = 1'b0;
        jmp_addr   = 8'h00;
        stall      = 1'b0;
    endtask

    // Leaves the bench on a falling edge with the DUT in its first FETCH cycle.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0h exp=0", halted); end
        checks++; if (pc_out !== 8'h00) begin failures++; $display("FAIL rst_pc got=%0h exp=00", pc_out); end
        checks++; if ({opcode, operand} !== 8'h00) begin failures++; $display("FAIL rst_ir got=%0h exp=00", {opcode, operand}); end
        checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Still IDLE until the first rising edge after release.
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%0h exp=0", imem_req); end
        @(negedge clk);
        checks++; if (state_dbg !== S_FETCH) begin failures++; $display("FAIL first_fetch_state got=%0d exp=%0d", state_dbg, S_FETCH); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_fetch_req got=%0h exp=1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL first_fetch_addr got=%0h exp=00", imem_addr); end
    endtask

    // Zero-wait fetch of 8'h12, then ack during EXEC must be ignored.
    task automatic test_first_fetch();
        imem_ack = 1'b1; imem_rdata = 8'h12;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (opcode !== 4'h1) begin failures++; $display("FAIL ff_opcode got=%0h exp=1", opcode); end
        checks++; if (operand !== 4'h2) begin failures++; $display("FAIL ff_operand got=%0h exp=2", operand); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL ff_valid got=%0h exp=1", instr_valid); end
        checks++; if (pc_out !== 8'h01) begin failures++; $display("FAIL ff_pc got=%0h exp=01", pc_out); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ff_exec_req got=%0h exp=0", imem_req); end
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 8'h55;
        @(negedge clk);
        checks++; if (state_dbg !== S_EXEC) begin failures++; $display("FAIL ign_ack_state got=%0d exp=%0d", state_dbg, S_EXEC); end
        checks++; if ({opcode, operand} !== 8'h12) begin failures++; $display("FAIL ign_ack_ir got=%0h exp=12", {opcode, operand}); end
        checks++; if (pc_out !== 8'h01) begin failures++; $display("FAIL ign_ack_pc got=%0h exp=01", pc_out); end
        stall = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (state_dbg !== S_FETCH) begin failures++; $display("FAIL fall_state got=%0d exp=%0d", state_dbg, S_FETCH); end
        checks++; if (imem_addr !== 8'h01) begin failures++; $display("FAIL fall_addr got=%0h exp=01", imem_addr); end
    endtask

    // Ack arrives in the 4th FETCH cycle; req/address stay put until then.
    task automatic test_wait_states();
        int req_cycles;
        do_reset();
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req === 1'b1) req_cycles++;
            checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL ws_addr cyc=%0d got=%0h exp=00", i, imem_addr); end
            @(negedge clk);
        end
        if (imem_req === 1'b1) req_cycles++;
        checks++; if (req_cycles !== 4) begin failures++; $display("FAIL ws_req_cycles got=%0d exp=4", req_cycles); end
        imem_ack = 1'b1; imem_rdata = 8'h34;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if ({opcode, operand} !== 8'h34) begin failures++; $display("FAIL ws_ir got=%0h exp=34", {opcode, operand}); end
        checks++; if (pc_out !== 8'h01) begin failures++; $display("FAIL ws_pc got=%0h exp=01 (single increment)", pc_out); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ws_req_drop got=%0h exp=0", imem_req); end
    endtask

    // Enters in EXEC with pc=1: stalled jump, released jump, then a self-loop.
    task automatic test_jump();
        jmp_sel = 1'b1; jmp_addr = 8'h40; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (state_dbg !== S_EXEC) begin failures++; $display("FAIL stall_state cyc=%0d got=%0d exp=%0d", i, state_dbg, S_EXEC); end
            checks++; if (pc_out !== 8'h01) begin failures++; $display("FAIL stall_pc cyc=%0d got=%0h exp=01", i, pc_out); end
        end
        stall = 1'b0;
        @(negedge clk);
        jmp_sel = 1'b0;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL jmp_req got=%0h exp=1", imem_req); end
        checks++; if (imem_addr !== 8'h40) begin failures++; $display("FAIL jmp_addr got=%0h exp=40", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 8'h21;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (pc_out !== 8'h41) begin failures++; $display("FAIL loop_pc_inc got=%0h exp=41", pc_out); end
        jmp_sel = 1'b1; jmp_addr = 8'h40;
        @(negedge clk);
        jmp_sel = 1'b0;
        checks++; if (imem_addr !== 8'h40) begin failures++; $display("FAIL self_loop_addr got=%0h exp=40", imem_addr); end
        checks++; if (state_dbg !== S_FETCH) begin failures++; $display("FAIL self_loop_state got=%0d exp=%0d", state_dbg, S_FETCH); end
    endtask

    // Enters in FETCH: jump to 0xFF, fetch there, fall through to 0x00.
    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 8'h21;
        @(negedge clk);
        imem_ack = 1'b0; jmp_sel = 1'b1; jmp_addr = 8'hFF;
        @(negedge clk);
        jmp_sel = 1'b0;
        checks++; if (imem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_pre_addr got=%0h exp=ff", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 8'h56;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (pc_out !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%0h exp=00", pc_out); end
        @(negedge clk);
        checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL wrap_addr got=%0h exp=00", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL wrap_req got=%0h exp=1", imem_req); end
    endtask

    // Enters in FETCH at address 0: HALT opcode wins over a taken jump.
    task automatic test_halt();
        imem_ack = 1'b1; imem_rdata = 8'hF0;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (opcode !== 4'hF) begin failures++; $display("FAIL halt_opcode got=%0h exp=f", opcode); end
        jmp_sel = 1'b1; jmp_addr = 8'h40;
        @(negedge clk);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%0h exp=1", halted); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%0h exp=0", instr_valid); end
        checks++; if (pc_out !== 8'h01) begin failures++; $display("FAIL halt_pc got=%0h exp=01", pc_out); end
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            stall    = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if ({imem_req, halted, state_dbg} !== {1'b0, 1'b1, S_HALT}) begin
                failures++; $display("FAIL halt_hold cyc=%0d got=req%0h/halt%0h/st%0d exp=req0/halt1/st3", i, imem_req, halted, state_dbg);
            end
        end
        do_reset();
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_exit got=%0h exp=0", halted); end
        checks++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin failures++; $display("FAIL halt_refetch got=%0h exp=100", {imem_req, imem_addr}); end
    endtask

    // Enters in FETCH at 0: move to address 1, then reset between edges.
    task automatic test_async_reset();
        imem_ack = 1'b1; imem_rdata = 8'h12;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (imem_addr !== 8'h01) begin failures++; $display("FAIL ar_pre_addr got=%0h exp=01", imem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ar_req_drop got=%0h exp=0", imem_req); end
        checks++; if (pc_out !== 8'h00) begin failures++; $display("FAIL ar_pc got=%0h exp=00", pc_out); end
        imem_ack = 1'b1; imem_rdata = 8'h77;
        @(negedge clk);
        checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL ar_hold_idle got=%0d exp=%0d", state_dbg, S_IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (state_dbg !== S_FETCH) begin failures++; $display("FAIL ar_restart_state got=%0d exp=%0d", state_dbg, S_FETCH); end
        checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL ar_restart_addr got=%0h exp=00", imem_addr); end
        checks++; if ({opcode, operand} !== 8'h00) begin failures++; $display("FAIL ar_ir got=%0h exp=00", {opcode, operand}); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_jump();
        test_wrap();
        do_reset();
        test_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8: program-counter and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 8: instruction width, with opcode = instr[INSTR_W-1:INSTR_W-4] and operand = instr[3:0].
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-006 SHALL have port imem_addr, output, PC_W: fetch address, equal to the PC.
REQ-007 SHALL have port imem_ack, input, 1: memory read data valid this cycle.
REQ-008 SHALL have port imem_rdata, input, INSTR_W: instruction word, sampled only when imem_req && imem_ack.
REQ-009 SHALL have port opcode, output, 4: registered opcode to the control unit.
REQ-010 SHALL have port operand, output, 4: registered low operand field.
REQ-011 SHALL have port instr_valid, output, 1: opcode/operand hold a live instruction in EXEC.
REQ-012 SHALL have port jmp_sel, input, 1: taken-jump decision from the control unit.
REQ-013 SHALL have port jmp_addr, input, PC_W: jump target from the datapath.
REQ-014 SHALL have port stall, input, 1: holds the current instruction in EXEC.
REQ-015 SHALL have port pc_out, output, PC_W: current PC, for debug and link.
REQ-016 SHALL have port halted, output, 1: core stopped on HALT (opcode 4'b1111).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-018 SHALL go IDLE->FETCH unconditionally on the first clock after reset release.
REQ-019 In FETCH, SHALL drive imem_req=1 with imem_addr=pc, and keep imem_req high until imem_ack.
REQ-020 On imem_ack in FETCH, SHALL latch imem_rdata into the instruction register, set pc <= pc+1 (mod 2^PC_W, 0xFF->0x00), and go to EXEC.
REQ-021 SHALL ignore imem_ack outside FETCH, with no state or register change.
REQ-022 In EXEC, SHALL drive instr_valid=1 and imem_req=0; opcode/operand visible one cycle after the ack cycle.
REQ-023 In EXEC with stall=1, SHALL hold state, PC and instruction register, and ignore jmp_sel.
REQ-024 In EXEC with stall=0 and opcode==4'b1111, SHALL go to HALT, with the PC unchanged; HALT takes priority over jmp_sel.
REQ-025 In EXEC with stall=0 and jmp_sel=1, SHALL set pc <= jmp_addr and go to FETCH.
REQ-026 In EXEC with stall=0 and jmp_sel=0, SHALL go to FETCH with the PC already incremented.
REQ-027 Minimum instruction period SHALL be 2 cycles, with zero-wait memory (ack in the first FETCH cycle).
REQ-028 In HALT, SHALL hold halted=1, imem_req=0 and instr_valid=0; only reset exits HALT.
REQ-029 A jump to the current PC (self-loop) SHALL be legal and refetch that address.

Reset
REQ-030 SHALL clear all state immediately on rst_n low, independent of clk: state=IDLE, pc=0, instruction register=0, imem_req=0, instr_valid=0, halted=0, opcode=0, operand=0.
REQ-031 Reset asserted mid-FETCH SHALL drop imem_req asynchronously, and any later ack SHALL be ignored.

Structure
REQ-032 Shared package cpu_pkg SHALL hold PC_W/INSTR_W defaults, the OPC_HALT constant (4'b1111) and the fetch-state enum.
REQ-033 The PC SHALL be a sub-module program_counter (load, increment, hold), instantiated once.

Verification
REQ-034 Reset release, ack in first FETCH cycle, rdata=8'h12 -> imem_addr=0, then opcode=1, operand=2, instr_valid=1 one cycle later, pc_out=1.
REQ-035 Ack delayed 3 cycles -> imem_req high for 4 cycles, address stable at 0, single latch.
REQ-036 EXEC with jmp_sel=1, jmp_addr=8'h40 -> next imem_addr=8'h40; same with stall=1 for 2 cycles -> held, then jump.
REQ-037 PC=8'hFF, fetch with no jump -> next imem_addr=8'h00.
REQ-038 rdata=8'hF0 with jmp_sel=1 -> HALT, halted=1, no further imem_req until rst_n pulse.
REQ-039 rst_n low mid-FETCH between edges -> imem_req=0 immediately; restart fetch from address 0.
